led_pwm_fader: RTL and testbench
================================

Name: led_pwm_fader

Overview:
Downstream output stage for the LED blinker. It takes the blinker's hard on/off LED level and drives the physical LED pin with a PWM signal. The PWM duty ramps up smoothly when the input goes high and ramps down when it goes low, giving a fade instead of a hard toggle. Single clock domain shared with the blinker; sits between the blinker output and the board pin.

Parameters:
PWM_BITS, 8, PWM counter width; PWM period = 2^PWM_BITS clk cycles
STEP_DIV, 4, number of PWM periods between duty steps while ramping (>=1)
STEP_SIZE, 16, duty increment/decrement per step (>=1)
DUTY_MAX, 256, full-on duty; must be <= 2^PWM_BITS (256 = 100% on at defaults)

Ports:
clk  input  1  system clock, the single clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
led_in  input  1  LED level from the blinker (same clock domain)
led_out  output  1  PWM-modulated LED drive, registered
duty  output  PWM_BITS+1  current duty value, unsigned, 0..DUTY_MAX
busy  output  1  1 while in RAMP_UP or RAMP_DOWN

Behaviour:
- Reset (rst_n=0 at a clk edge): state=OFF, duty=0, pwm_cnt=0, step_cnt=0, led_in_q=0, led_out=0, busy=0. Reset applied mid-ramp aborts the ramp immediately; no fade-out.
- led_in is registered once (led_in_q). All decisions use led_in_q.
- pwm_cnt: free-running, PWM_BITS wide, increments every cycle, wraps 2^PWM_BITS-1 -> 0. "Period boundary" = the cycle in which pwm_cnt == 2^PWM_BITS-1.
- led_out <= (pwm_cnt < duty), registered each cycle. Compare is unsigned and PWM_BITS+1 wide.
  - duty=0 gives constant 0.
  - duty=2^PWM_BITS gives constant 1.
- duty changes only on period boundaries, so there are no runt pulses within a period.
- FSM states: OFF, RAMP_UP, ON, RAMP_DOWN. Transitions are evaluated every cycle:
  - OFF: duty held at 0. led_in_q=1 -> RAMP_UP, step_cnt<=0.
  - RAMP_UP:
    - led_in_q=0 -> RAMP_DOWN, step_cnt<=0. The ramp reverses from the current duty with no jump.
    - Otherwise, at each period boundary: if step_cnt==STEP_DIV-1, then step_cnt<=0 and duty<=min(duty+STEP_SIZE, DUTY_MAX). Else step_cnt++.
    - When the updated duty equals DUTY_MAX -> ON on the same boundary.
  - ON: duty held at DUTY_MAX. led_in_q=0 -> RAMP_DOWN, step_cnt<=0.
  - RAMP_DOWN:
    - Mirror of RAMP_UP. duty<=(duty<=STEP_SIZE) ? 0 : duty-STEP_SIZE. There is no underflow.
    - Reaching 0 -> OFF. led_in_q=1 -> RAMP_UP, step_cnt<=0.
- Simultaneous events: a direction change on a period boundary takes priority. No step is applied on that boundary; the new ramp starts counting from step_cnt=0.
- busy = (state==RAMP_UP || state==RAMP_DOWN), registered with the state.
- led_in pulses shorter than one PWM period are honoured: the direction reverses, and duty moves by at most whatever steps were completed.
- Full-scale ramp time = ceil(DUTY_MAX/STEP_SIZE) * STEP_DIV * 2^PWM_BITS cycles, plus alignment to the next boundary.
- Input to output latency: a change on led_in changes the state 2 cycles later (register, then FSM). The first duty step is applied at the STEP_DIV-th subsequent period boundary.

Test Plan:
All scenarios use PWM_BITS=4, STEP_DIV=2, STEP_SIZE=4, DUTY_MAX=16.
1. Reset: hold rst_n=0 for 3 cycles with led_in=1 -> led_out=0, duty=0, busy=0 throughout. After release, busy=1 within 2 cycles.
2. Full ramp up: led_in=1 from OFF -> duty steps 0,4,8,12,16, one step every 32 cycles, each aligned to pwm_cnt wrap. busy drops to 0 when duty=16. led_out is then constantly 1.
3. PWM shape: freeze at duty=4 in RAMP_UP -> led_out is high for exactly 4 of every 16 cycles, rising 1 cycle after pwm_cnt=0.
4. Mid-ramp reversal: drop led_in at duty=8 -> duty goes 8,4,0 with no jump upward, then state=OFF, busy=0, led_out stays 0.
5. Full ramp down from ON: led_in=0 -> duty steps 16,12,8,4,0; led_out is constantly 0 at the end.
6. Reset mid-ramp: assert rst_n=0 at duty=12 -> on the next edge duty=0, led_out=0, state=OFF.

Source files
------------

// File: rtl/led_pwm_fader.sv
// PWM output stage for the LED blinker: fades the LED pin up/down instead of
// toggling hard, stepping duty only on PWM period boundaries.
module led_pwm_fader #(
  parameter int PWM_BITS  = 8,
  parameter int STEP_DIV  = 4,
  parameter int STEP_SIZE = 16,
  parameter int DUTY_MAX  = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                led_in,
  output logic                led_out,
  output logic [PWM_BITS:0]   duty,
  output logic                busy
);

  localparam int DW = PWM_BITS + 1;
  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DW-1:0] DMAX      = DW'(DUTY_MAX);
  localparam logic [DW-1:0] STEP      = DW'(STEP_SIZE);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);

  typedef enum logic [1:0] {OFF, RAMP_UP, ON, RAMP_DOWN} state_t;

  state_t              state;
  logic                led_in_p0;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [SW-1:0]       step_cnt;
  logic                boundary;
  logic [DW-1:0]       duty_up;
  logic [DW-1:0]       duty_dn;

  // Saturating step towards full-on; the extra bit keeps the sum from wrapping.
  function automatic logic [DW-1:0] sat_up(input logic [DW-1:0] d);
    logic [DW:0] s;
    s = {1'b0, d} + {1'b0, STEP};
    return (s >= {1'b0, DMAX}) ? DMAX : s[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] sat_dn(input logic [DW-1:0] d);
    return (d <= STEP) ? '0 : d - STEP;
  endfunction

  assign boundary = (pwm_cnt == '1);
  assign duty_up  = sat_up(duty);
  assign duty_dn  = sat_dn(duty);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= OFF;
      led_in_p0 <= 1'b0;
      pwm_cnt   <= '0;
      step_cnt  <= '0;
      duty      <= '0;
      led_out   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // Stage p0: input register and free-running PWM counter
      led_in_p0 <= led_in;
      pwm_cnt   <= pwm_cnt + 1'b1;
      // Stage p1: PWM compare against the duty held for this period
      led_out   <= ({1'b0, pwm_cnt} < duty);

      case (state)
        OFF: begin
          duty <= '0;
          if (led_in_p0) begin
            state    <= RAMP_UP;
            step_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        RAMP_UP: begin
          // A direction change wins over a step falling on the same boundary.
          if (!led_in_p0) begin
            state    <= RAMP_DOWN;
            step_cnt <= '0;
          end else if (boundary) begin
            if (step_cnt == STEP_LAST) begin
              step_cnt <= '0;
              duty     <= duty_up;
              if (duty_up == DMAX) begin
                state <= ON;
                busy  <= 1'b0;
              end
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
        end
        ON: begin
          duty <= DMAX;
          if (!led_in_p0) begin
            state    <= RAMP_DOWN;
            step_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        RAMP_DOWN: begin
          if (led_in_p0) begin
            state    <= RAMP_UP;
            step_cnt <= '0;
          end else if (boundary) begin
            if (step_cnt == STEP_LAST) begin
              step_cnt <= '0;
              duty     <= duty_dn;
              if (duty_dn == '0) begin
                state <= OFF;
                busy  <= 1'b0;
              end
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= OFF;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader at PWM_BITS=4, STEP_DIV=2, STEP_SIZE=4, DUTY_MAX=16.
module tb_led_pwm_fader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       led_in;
  logic       led_out;
  logic [4:0] duty;
  logic       busy;

  led_pwm_fader #(
    .PWM_BITS(4), .STEP_DIV(2), .STEP_SIZE(4), .DUTY_MAX(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .led_in(led_in),
    .led_out(led_out), .duty(duty), .busy(busy)
  );

  always #5 clk = ~clk;

  // cyc: cycle index after reset release; led: led_in driven after that cycle;
  // hi: number of led_out-high cycles since the previous record.
  typedef struct {
    int         cyc;
    logic       led;
    logic [4:0] duty;
    logic       busy;
    int         hi;
  } vec_t;

  vec_t vq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic add(input int c, input logic l, input int d, input logic b, input int h);
    vec_t r;
    r.cyc = c; r.led = l; r.duty = 5'(d); r.busy = b; r.hi = h;
    vq.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    int hi;
    int max_duty;

    // Full ramp up, PWM shape at duty 4, constant-on at full duty
    add(  1, 1,  0, 0,  0);
    add(  2, 1,  0, 1,  0);
    add( 31, 1,  0, 1,  0);
    add( 32, 1,  4, 1,  0);
    add( 36, 1,  4, 1,  4);
    add( 48, 1,  4, 1,  0);
    add( 63, 1,  4, 1,  4);
    add( 64, 1,  8, 1,  0);
    add( 96, 1, 12, 1, 16);
    add(128, 1, 16, 0, 24);
    add(160, 0, 16, 0, 32);
    // Full ramp down from ON
    add(162, 0, 16, 1,  2);
    add(191, 0, 16, 1, 29);
    add(192, 0, 12, 1,  1);
    add(224, 0,  8, 1, 24);
    add(256, 0,  4, 1, 16);
    add(288, 0,  0, 0,  8);
    add(320, 1,  0, 0,  0);
    // Ramp up to 8, then reverse mid-ramp
    add(322, 1,  0, 1,  0);
    add(352, 1,  4, 1,  0);
    add(384, 0,  8, 1,  8);
    add(386, 0,  8, 1,  2);
    add(416, 0,  4, 1, 14);
    add(448, 0,  0, 0,  8);
    add(480, 1,  0, 0,  0);
    // Ramp up to 12 ahead of a mid-ramp reset
    add(482, 1,  0, 1,  0);
    add(576, 1, 12, 1, 24);

    // Reset held with led_in high
    rst_n  = 1'b0;
    led_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_led_out", 32'(led_out), 0);
      chk("reset_duty",    32'(duty),    0);
      chk("reset_busy",    32'(busy),    0);
    end
    rst_n = 1'b1;

    cyc = 0;
    hi  = 0;
    max_duty = 0;
    for (int i = 0; i < vq.size(); i++) begin
      while (cyc < vq[i].cyc) begin
        tick();
        cyc++;
        if (led_out === 1'b1) hi++;
        if (cyc > 384 && cyc <= 448 && int'(duty) > max_duty) max_duty = int'(duty);
      end
      chk($sformatf("duty@%0d", cyc), 32'(duty), 32'(vq[i].duty));
      chk($sformatf("busy@%0d", cyc), 32'(busy), 32'(vq[i].busy));
      chk($sformatf("led_out_highs@%0d", cyc), 32'(hi), 32'(vq[i].hi));
      hi = 0;
      led_in = vq[i].led;
    end
    chk("reversal_max_duty", 32'(max_duty), 8);

    // Reset at duty 12 mid-ramp: cleared on the very next edge, no fade-out
    rst_n = 1'b0;
    tick();
    chk("midreset_duty",    32'(duty),    0);
    chk("midreset_led_out", 32'(led_out), 0);
    chk("midreset_busy",    32'(busy),    0);
    led_in = 1'b0;
    rst_n  = 1'b1;
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (led_out === 1'b1 || busy !== 1'b0 || duty !== 5'd0) hi++;
    end
    chk("after_reset_idle_violations", 32'(hi), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
